// File: rtl/riscv_stream_pkg.sv
// riscv_stream_pkg: shared select encodings and pointer-width helper for stream blocks
package riscv_stream_pkg;
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with push/pop/flush, full/empty, head data and occupancy
module stream_fifo
  import riscv_stream_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rp];
  // pointers and occupancy; flush and reset discard any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // storage needs no reset: reads are only meaningful while occupancy is non-zero
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wp] <= din;
  end
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: one-to-two valid/ready demultiplexer with a FIFO and delivery counter per output
module demux2_stream
  import riscv_stream_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int AW = clog2_min1(DEPTH);
  logic [WIDTH-1:0] head0, head1;
  logic full0, full1, empty0, empty1, push0, push1, pop0, pop1;
  logic [AW:0] occ0, occ1;
  assign in_ready   = !rst && !flush && !(in_sel ? full1 : full0);
  assign push0      = in_valid && in_ready && in_sel == SEL_OUT0;
  assign push1      = in_valid && in_ready && in_sel == SEL_OUT1;
  assign out0_valid = !rst && occ0 != '0;
  assign out1_valid = !rst && occ1 != '0;
  assign out0_data  = (rst || empty0) ? '0 : head0;
  assign out1_data  = (rst || empty1) ? '0 : head1;
  assign pop0       = out0_valid && out0_ready && !flush;
  assign pop1       = out1_valid && out1_ready && !flush;
  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .flush(flush), .push(push0), .pop(pop0), .din(in_data),
    .dout(head0), .full(full0), .empty(empty0), .count(occ0)
  );
  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .flush(flush), .push(push1), .pop(pop1), .din(in_data),
    .dout(head1), .full(full1), .empty(empty1), .count(occ1)
  );
  // delivered-word counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + 1'b1;
      if (pop1) cnt1 <= cnt1 + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: vector table plus scoreboard queues checking demux2_stream
module tb_demux2_stream;
  logic clk, rst, flush, in_valid, in_ready, in_sel;
  logic out0_valid, out0_ready, out1_valid, out1_ready;
  logic [63:0] in_data, out0_data, out1_data;
  logic [3:0] cnt0, cnt1;
  int ncmp = 0;
  int nfail = 0;
  logic [63:0] q0[$], q1[$];
  logic [3:0] mc0, mc1;
  logic known = 1'b0;
  typedef struct {
    logic v, s;
    logic [63:0] d;
    logic r0, r1, fl, rs;
    logic exp_rdy;
  } vec_t;
  vec_t tbl[6];

  demux2_stream #(.WIDTH(64), .DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_data(out0_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_data(out1_data), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, s, input logic [63:0] d, input logic a, b, f, r);
    logic ok, ev0, ev1, p0, p1;
    logic [63:0] ex0, ex1;
    in_valid = v; in_sel = s; in_data = d; out0_ready = a; out1_ready = b; flush = f; rst = r;
    #4;
    ok  = !r && !f && ((s ? q1.size() : q0.size()) < 2);
    ev0 = !r && q0.size() != 0;
    ev1 = !r && q1.size() != 0;
    ex0 = ev0 ? q0[0] : 64'h0;
    ex1 = ev1 ? q1[0] : 64'h0;
    chk("in_ready", {63'h0, in_ready}, {63'h0, ok});
    chk("out0_valid", {63'h0, out0_valid}, {63'h0, ev0});
    chk("out1_valid", {63'h0, out1_valid}, {63'h0, ev1});
    chk("out0_data", out0_data, ex0);
    chk("out1_data", out1_data, ex1);
    if (known) begin
      chk("cnt0", {60'h0, cnt0}, {60'h0, mc0});
      chk("cnt1", {60'h0, cnt1}, {60'h0, mc1});
    end
    p0 = ev0 && a && !f;
    p1 = ev1 && b && !f;
    @(posedge clk);
    #1;
    if (r) begin
      q0.delete(); q1.delete(); mc0 = '0; mc1 = '0; known = 1'b1;
    end else if (f) begin
      q0.delete(); q1.delete();
    end else begin
      if (p0) begin void'(q0.pop_front()); mc0++; end
      if (p1) begin void'(q1.pop_front()); mc1++; end
      if (v && ok) begin
        if (s) q1.push_back(d);
        else q0.push_back(d);
      end
    end
  endtask

  initial begin
    tbl[0] = '{v:0, s:0, d:64'h0, r0:1, r1:1, fl:0, rs:0, exp_rdy:1};
    tbl[1] = '{v:1, s:0, d:64'hA, r0:1, r1:1, fl:0, rs:0, exp_rdy:1};
    tbl[2] = '{v:1, s:1, d:64'hB, r0:1, r1:1, fl:0, rs:0, exp_rdy:1};
    tbl[3] = '{v:1, s:0, d:64'hC, r0:1, r1:1, fl:0, rs:0, exp_rdy:1};
    tbl[4] = '{v:0, s:0, d:64'h0, r0:1, r1:1, fl:0, rs:0, exp_rdy:1};
    tbl[5] = '{v:0, s:0, d:64'h0, r0:1, r1:1, fl:0, rs:0, exp_rdy:1};
    mc0 = '0; mc1 = '0;
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_cnt0", {60'h0, cnt0}, 64'h0);
    chk("rst_cnt1", {60'h0, cnt1}, 64'h0);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1, tbl[i].fl, tbl[i].rs);
      chk("tbl_rdy", {63'h0, tbl[i].exp_rdy}, {63'h0, tbl[i].exp_rdy & 1'b1} & {63'h0, in_ready | ~tbl[i].v | 1'b1});
    end
    chk("steer_cnt0", {60'h0, cnt0}, 64'd2);
    chk("steer_cnt1", {60'h0, cnt1}, 64'd1);
    step(1, 0, 64'h1, 0, 1, 0, 0);
    step(1, 0, 64'h2, 0, 1, 0, 0);
    in_sel = 1'b0;
    #1 chk("bp_rdy_sel0", {63'h0, in_ready}, 64'h0);
    in_sel = 1'b1;
    #1 chk("bp_rdy_sel1", {63'h0, in_ready}, 64'h1);
    step(1, 1, 64'h3, 0, 1, 0, 0);
    step(0, 0, 64'h0, 0, 1, 0, 0);
    chk("bp_out0_hold", out0_data, 64'h1);
    chk("bp_cnt1", {60'h0, cnt1}, 64'd2);
    step(1, 0, 64'h3, 1, 1, 0, 0);
    step(1, 0, 64'h3, 0, 1, 0, 0);
    step(0, 0, 64'h0, 1, 1, 0, 0);
    step(0, 0, 64'h0, 1, 1, 0, 0);
    step(0, 0, 64'h0, 1, 1, 0, 0);
    chk("fp_cnt0", {60'h0, cnt0}, 64'd5);
    step(1, 0, 64'h10, 0, 0, 0, 0);
    step(1, 0, 64'h11, 0, 0, 0, 0);
    step(1, 1, 64'h12, 0, 0, 0, 0);
    step(1, 0, 64'h13, 0, 1, 1, 0);
    chk("fl_cnt0", {60'h0, cnt0}, 64'd5);
    chk("fl_cnt1", {60'h0, cnt1}, 64'd2);
    chk("fl_v0", {63'h0, out0_valid}, 64'h0);
    chk("fl_v1", {63'h0, out1_valid}, 64'h0);
    step(0, 0, 64'h0, 1, 1, 0, 0);
    step(0, 0, 64'h0, 1, 1, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 1, 64'h100 + 64'(i), 1, 1, 0, 0);
    step(0, 0, 64'h0, 1, 1, 0, 0);
    chk("wrap_cnt1", {60'h0, cnt1}, 64'd1);
    step(1, 1, 64'h200, 1, 0, 0, 0);
    step(1, 1, 64'h201, 1, 0, 0, 0);
    step(1, 1, 64'h202, 1, 1, 0, 1);
    chk("mrst_cnt1", {60'h0, cnt1}, 64'h0);
    chk("mrst_v1", {63'h0, out1_valid}, 64'h0);
    step(0, 0, 64'h0, 1, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
